// File: rtl/hack_cpu_mc.sv
// hack_cpu_mc: multi-cycle Hack CPU core with ready/valid memory handshakes.
//
// Executes the Hack instruction set and runs against variable-latency instruction ROM
// and data RAM. It reports each committed instruction and detects the `(END) @END; 0;JMP`
// idiom as a halt.
//
// Ports:
//   clk_i, reset_ni        clock (rising edge), asynchronous active-low reset
//   inst_i, inst_valid_i   instruction word for pc_o and its valid flag
//   pc_o                   fetch address
//   data_i, data_valid_i   read data (M) and its valid flag for an outstanding read
//   dmem_rd_en_o           read request, held until data_valid_i
//   dmem_wr_en_o           write request, held until dmem_ready_i
//   dmem_ready_i           write accepted this cycle
//   dmem_addr_o            data address, the low bits of A
//   data_o                 registered write data (latched ALU result)
//   retire_o               one-cycle pulse per committed instruction
//   halt_o                 sticky halt flag
module hack_cpu_mc #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic [DATA_WIDTH-1:0] inst_i,
    input  logic                  inst_valid_i,
    output logic [ADDR_WIDTH-1:0] pc_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  data_valid_i,
    output logic                  dmem_rd_en_o,
    output logic                  dmem_wr_en_o,
    input  logic                  dmem_ready_i,
    output logic [ADDR_WIDTH-1:0] dmem_addr_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  retire_o,
    output logic                  halt_o
);

    localparam logic [ADDR_WIDTH-1:0] ResetPc = ADDR_WIDTH'(RESET_PC);
    localparam logic [ADDR_WIDTH-1:0] PcOne   = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        StFetch,
        StRead,
        StExec,
        StWrite,
        StHalt
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] reg_a_q, reg_a_d;
    logic [DATA_WIDTH-1:0] reg_d_q, reg_d_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    // Only the C-instruction fields are kept; A-instructions commit straight from inst_i.
    logic [12:0]           ir_q, ir_d;
    logic [DATA_WIDTH-1:0] mlat_q, mlat_d;
    logic [DATA_WIDTH-1:0] alu_q, alu_d;
    logic                  prev_a_q, prev_a_d;
    logic                  halt_q, halt_d;
    logic                  retire_q, retire_d;

    // Decoded C-instruction fields
    logic       ir_a;
    logic       zx, nx, zy, ny, fn, no;
    logic       dest_a, dest_d, dest_m;
    logic [2:0] jmp;

    assign ir_a   = ir_q[12];
    assign zx     = ir_q[11];
    assign nx     = ir_q[10];
    assign zy     = ir_q[9];
    assign ny     = ir_q[8];
    assign fn     = ir_q[7];
    assign no     = ir_q[6];
    assign dest_a = ir_q[5];
    assign dest_d = ir_q[4];
    assign dest_m = ir_q[3];
    assign jmp    = ir_q[2:0];

    logic [DATA_WIDTH-1:0] alu_x, alu_y, alu_out;

    always_comb begin
        alu_x = zx ? '0 : reg_d_q;
        if (nx) begin
            alu_x = ~alu_x;
        end
        alu_y = ir_a ? mlat_q : reg_a_q;
        if (zy) begin
            alu_y = '0;
        end
        if (ny) begin
            alu_y = ~alu_y;
        end
        alu_out = fn ? (alu_x + alu_y) : (alu_x & alu_y);
        if (no) begin
            alu_out = ~alu_out;
        end
    end

    // In WRITE the result was latched in EXEC; A, D and M are untouched since then.
    logic [DATA_WIDTH-1:0] result;
    logic                  res_ng, res_zr, take_jump, halt_hit;
    logic [ADDR_WIDTH-1:0] jmp_tgt, pc_inc, pc_dec;

    assign result    = (state_q == StWrite) ? alu_q : alu_out;
    assign res_ng    = result[DATA_WIDTH-1];
    assign res_zr    = (result == '0);
    assign take_jump = (jmp[2] & res_ng) | (jmp[1] & res_zr) | (jmp[0] & ~res_ng & ~res_zr);
    assign jmp_tgt   = reg_a_q[ADDR_WIDTH-1:0];
    assign pc_inc    = pc_q + PcOne;
    assign pc_dec    = pc_q - PcOne;
    // `(END) @END; 0;JMP`: unconditional jump back onto the preceding @END.
    assign halt_hit  = take_jump && (jmp == 3'b111) && prev_a_q && (jmp_tgt == pc_dec);

    logic commit_c;

    always_comb begin
        state_d  = state_q;
        reg_a_d  = reg_a_q;
        reg_d_d  = reg_d_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        mlat_d   = mlat_q;
        alu_d    = alu_q;
        prev_a_d = prev_a_q;
        halt_d   = halt_q;
        retire_d = 1'b0;
        commit_c = 1'b0;

        unique case (state_q)
            StFetch: begin
                if (inst_valid_i) begin
                    ir_d = inst_i[12:0];
                    if (!inst_i[DATA_WIDTH-1]) begin
                        reg_a_d  = {1'b0, inst_i[DATA_WIDTH-2:0]};
                        pc_d     = pc_inc;
                        prev_a_d = 1'b1;
                        retire_d = 1'b1;
                    end else if (inst_i[12]) begin
                        state_d = StRead;
                    end else begin
                        state_d = StExec;
                    end
                end
            end
            StRead: begin
                if (data_valid_i) begin
                    mlat_d  = data_i;
                    state_d = StExec;
                end
            end
            StExec: begin
                alu_d = alu_out;
                if (dest_m) begin
                    state_d = StWrite;
                end else begin
                    commit_c = 1'b1;
                end
            end
            StWrite: begin
                if (dmem_ready_i) begin
                    commit_c = 1'b1;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StFetch;
            end
        endcase

        if (commit_c) begin
            if (dest_a) begin
                reg_a_d = result;
            end
            if (dest_d) begin
                reg_d_d = result;
            end
            pc_d     = take_jump ? jmp_tgt : pc_inc;
            prev_a_d = 1'b0;
            retire_d = 1'b1;
            if (halt_hit) begin
                halt_d  = 1'b1;
                state_d = StHalt;
            end else begin
                state_d = StFetch;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= StFetch;
            reg_a_q  <= '0;
            reg_d_q  <= '0;
            pc_q     <= ResetPc;
            ir_q     <= '0;
            mlat_q   <= '0;
            alu_q    <= '0;
            prev_a_q <= 1'b0;
            halt_q   <= 1'b0;
            retire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            reg_a_q  <= reg_a_d;
            reg_d_q  <= reg_d_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            mlat_q   <= mlat_d;
            alu_q    <= alu_d;
            prev_a_q <= prev_a_d;
            halt_q   <= halt_d;
            retire_q <= retire_d;
        end
    end

    assign pc_o         = pc_q;
    assign dmem_rd_en_o = (state_q == StRead);
    assign dmem_wr_en_o = (state_q == StWrite);
    assign dmem_addr_o  = reg_a_q[ADDR_WIDTH-1:0];
    assign data_o       = alu_q;
    assign retire_o     = retire_q;
    assign halt_o       = halt_q;

endmodule

// File: doc/hack_cpu_mc.md
# hack_cpu_mc

Multi-cycle, parametrised successor to the single-cycle Hack CPU core. It executes the Hack instruction set and adds ready/valid handshakes on instruction fetch, data read and data write, so it can run against variable-latency ROM/RAM. It also adds a retire strobe and halt detection. It sits between the instruction ROM and data RAM in the top-level computer, replacing the single-cycle core when memories are not zero-latency.

## Interface
Parameters:
- DATA_WIDTH, 16, datapath/register width; must be >= 16
- ADDR_WIDTH, 15, PC and data-address width; must be <= DATA_WIDTH-1
- RESET_PC, 0, PC value after reset

Ports:
- clk_i  in  1  single clock, rising edge
- reset_ni  in  1  asynchronous, active-low reset
- inst_i  in  DATA_WIDTH  instruction word for address pc_o
- inst_valid_i  in  1  inst_i valid this cycle
- pc_o  out  ADDR_WIDTH  fetch address
- data_i  in  DATA_WIDTH  read data (M)
- data_valid_i  in  1  data_i valid for the outstanding read
- dmem_rd_en_o  out  1  read request, held until data_valid_i
- dmem_wr_en_o  out  1  write request, held until dmem_ready_i
- dmem_ready_i  in  1  write accepted this cycle
- dmem_addr_o  out  ADDR_WIDTH  data address = A[ADDR_WIDTH-1:0]
- data_o  out  DATA_WIDTH  registered write data (latched ALU result)
- retire_o  out  1  one-cycle pulse per committed instruction
- halt_o  out  1  sticky halt flag

## Operation
- Registers: A, D, PC, IR, M-latch, ALU-result latch (alu_q), prev_was_a flag, halt flag.
- Decode (fixed bit positions):
  - inst[DATA_WIDTH-1] = 0: A-instruction. A <= zero-extended inst[DATA_WIDTH-2:0].
  - Otherwise C-instruction with fields a=inst[12], c=inst[11:6] (zx,nx,zy,ny,f,no), d=inst[5:3] (A,D,M), j=inst[2:0] (lt,eq,gt).
- ALU: standard Hack function at DATA_WIDTH.
  - x = D; y = a ? M-latch : A.
  - ng = msb(out); zr = (out == 0).
- Jump when (j[2]&ng) | (j[1]&zr) | (j[0]&~ng&~zr). Target is A before update, truncated to ADDR_WIDTH. Otherwise PC <= PC+1, wrapping mod 2^ADDR_WIDTH.
- Commit updates A/D (per d bits), PC, prev_was_a and retire_o in one cycle. A write to M uses the pre-commit A.
- FSM:
  - FETCH: wait inst_valid_i; latch IR.
    - A-instr: commit immediately, stay FETCH.
    - C-instr with a=1: go READ.
    - Otherwise: go EXEC.
  - READ: dmem_rd_en_o=1. On data_valid_i, latch M and go EXEC.
  - EXEC: compute ALU and latch alu_q/data_o.
    - If d[0] (M): go WRITE.
    - Otherwise: commit and go FETCH (or HALT).
  - WRITE: dmem_wr_en_o=1 with data_o and dmem_addr_o stable. On dmem_ready_i, commit and go FETCH (or HALT).
  - HALT: terminal. No strobes, no retire; pc_o holds the jump target. Only reset exits.
- Halt detect: an unconditional jump (j=111) is taken, prev_was_a=1, and the target equals PC-1 (the `(END) @END; 0;JMP` idiom). The instruction commits, halt_o sets, and the FSM enters HALT.
- Inputs are ignored outside their own state:
  - inst_valid_i outside FETCH
  - data_valid_i outside READ
  - dmem_ready_i outside WRITE

## Timing
- Reset (async assert, sync-safe release) gives: FETCH, PC=RESET_PC, A=D=0, data_o=0, retire_o=0, halt_o=0, dmem_rd_en_o=0, dmem_wr_en_o=0, prev_was_a=0.
- Reset mid-READ/WRITE drops strobes in the same cycle and discards the uncommitted instruction.
- Minimum latency with zero-wait handshakes:
  - A-instr: 1 cycle.
  - C-instr with no M access: 2 cycles.
  - C-instr with M read: 3 cycles.
  - C-instr with M write: 3 cycles.
  - C-instr with M read and M write: 4 cycles.
- Each handshake wait cycle adds one cycle.
- A handshake may complete in the same cycle its strobe first asserts.
- pc_o changes only on commit. retire_o is high in exactly the commit cycle.
- dmem_addr_o, data_o and strobes are registered/state-decoded, so there is no combinational path from inputs to outputs.

## Test plan
- Reset with inst_valid_i=1 -> pc_o=RESET_PC, all strobes 0, halt_o=0. Deassert reset_ni mid-WRITE -> dmem_wr_en_o drops the same cycle, D unchanged.
- @5; D=A; @7; D=D+A; @0; M=D, all zero-wait -> single write: dmem_addr_o=0, data_o=12. retire_o pulses 6 times (including the commit of M=D, which follows the write handshake).
- @3; M=1 with dmem_ready_i low for 4 cycles -> dmem_wr_en_o held 5 cycles with addr=3, data=1, then commit.
- @0; D=M with data_valid_i delayed 3 cycles and data_i=0x8000 -> D=0x8000. A following @10; D;JLT jumps (pc_o=10); D;JGT does not (PC+1).
- ADDR_WIDTH=15 at PC=0x7FFF: non-jump C-instr -> pc_o wraps to 0.
- Program with `(END) @END; 0;JMP` at 20/21 -> halt_o sets on the commit of 0;JMP and pc_o=20. No further retire_o or strobes for 50 cycles despite inst_valid_i=1.
